// File: rtl/regfile_bist.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_bist
//  Purpose  : Built-in self-test sequencer for a 32 x 32-bit, 2-read/1-write
//             register file with register 0 hardwired to zero. Writes a
//             marker to reg 0, fills regs 1..31 with P(r), then drives
//             NOWE_DATA with the write enable low, then reads every register
//             through both read ports in opposite orders and classifies the
//             first mismatch.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk            in   1   clock, positive edge
//    Reset_n        in   1   synchronous reset, active low
//    Start          in   1   begin self-test (sampled in IDLE or DONE)
//    ReadData1      in  32   regfile port-1 read data
//    ReadData2      in  32   regfile port-2 read data
//    WriteData      out 32   regfile write data
//    ReadRegister1  out  5   regfile port-1 address
//    ReadRegister2  out  5   regfile port-2 address
//    WriteRegister  out  5   regfile write address
//    RegWrite       out  1   regfile write enable
//    Busy           out  1   test in progress
//    Done           out  1   test finished, results valid
//    Pass           out  1   all checks passed (valid when Done=1)
//    FailCode       out  3   first failure class: 1 ZERO, 2 WREN, 3 DATA1,
//                            4 DATA2 (valid when Done=1)
//    FailReg        out  5   address on failing port (valid when Done=1)
// ============================================================================
module regfile_bist #(
    parameter logic [15:0] PATTERN_HI = 16'hA5A5,
    parameter logic [31:0] NOWE_DATA  = 32'hDEADBEEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    output logic [31:0] WriteData,
    output logic [4:0]  ReadRegister1,
    output logic [4:0]  ReadRegister2,
    output logic [4:0]  WriteRegister,
    output logic        RegWrite,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [2:0]  FailCode,
    output logic [4:0]  FailReg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRZ   = 3'd1,
        S_FILL  = 3'd2,
        S_NOWE  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [2:0]  C_CODE_NONE  = 3'd0;
    localparam logic [2:0]  C_CODE_ZERO  = 3'd1;
    localparam logic [2:0]  C_CODE_WREN  = 3'd2;
    localparam logic [2:0]  C_CODE_DATA1 = 3'd3;
    localparam logic [2:0]  C_CODE_DATA2 = 3'd4;
    localparam logic [4:0]  C_LAST_REG   = 5'd31;
    localparam logic [31:0] C_WRZ_DATA   = 32'hFFFF_FFFF;

    // Fill pattern: upper half fixed, register index in the low bits.
    function automatic logic [31:0] pattern(input logic [4:0] idx);
        return {PATTERN_HI, 11'd0, idx};
    endfunction

    // Value a healthy register file returns for a given address.
    function automatic logic [31:0] expected(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : pattern(idx);
    endfunction

    // ------------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [4:0]  r_q, r_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [2:0]  fail_code_q, fail_code_d;
    logic [4:0]  fail_reg_q, fail_reg_d;

    // Regfile-facing outputs are registered and decoded from the next state,
    // so they line up with the state they belong to.
    logic [31:0] write_data_q, write_data_d;
    logic [4:0]  rd_reg1_q, rd_reg1_d;
    logic [4:0]  rd_reg2_q, rd_reg2_d;
    logic [4:0]  wr_reg_q, wr_reg_d;
    logic        reg_write_q, reg_write_d;
    logic        busy_q, busy_d;

    // ------------------------------------------------------------------------
    // Read-back comparison (meaningful only in CHECK)
    // ------------------------------------------------------------------------
    logic [4:0]  chk_addr1, chk_addr2;
    logic        mm1, mm2;
    logic        chk_fail;
    logic [2:0]  chk_code;
    logic [4:0]  chk_reg;

    always_comb begin
        chk_addr1 = r_q;
        chk_addr2 = C_LAST_REG - r_q;
        mm1       = (ReadData1 != expected(chk_addr1));
        mm2       = (ReadData2 != expected(chk_addr2));
        chk_fail  = mm1 | mm2;
        chk_code  = C_CODE_NONE;
        chk_reg   = 5'd0;

        // Priority ZERO > WREN > DATA1 > DATA2; within a class port 1 wins.
        // A nonzero read of reg 0 is always a mismatch, so mm gates it too.
        if (mm1 && chk_addr1 == 5'd0) begin
            chk_code = C_CODE_ZERO;
            chk_reg  = chk_addr1;
        end else if (mm2 && chk_addr2 == 5'd0) begin
            chk_code = C_CODE_ZERO;
            chk_reg  = chk_addr2;
        end else if (mm1 && ReadData1 == NOWE_DATA) begin
            chk_code = C_CODE_WREN;
            chk_reg  = chk_addr1;
        end else if (mm2 && ReadData2 == NOWE_DATA) begin
            chk_code = C_CODE_WREN;
            chk_reg  = chk_addr2;
        end else if (mm1) begin
            chk_code = C_CODE_DATA1;
            chk_reg  = chk_addr1;
        end else if (mm2) begin
            chk_code = C_CODE_DATA2;
            chk_reg  = chk_addr2;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, index and result logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_code_d = fail_code_q;
        fail_reg_d  = fail_reg_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d     = S_WRZ;
                    r_d         = 5'd0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_code_d = C_CODE_NONE;
                    fail_reg_d  = 5'd0;
                end
            end
            S_WRZ: begin
                state_d = S_FILL;
                r_d     = 5'd1;
            end
            S_FILL: begin
                if (r_q == C_LAST_REG) begin
                    state_d = S_NOWE;
                    r_d     = 5'd1;
                end else begin
                    r_d = r_q + 5'd1;
                end
            end
            S_NOWE: begin
                if (r_q == C_LAST_REG) begin
                    state_d = S_CHECK;
                    r_d     = 5'd0;
                end else begin
                    r_d = r_q + 5'd1;
                end
            end
            S_CHECK: begin
                if (chk_fail) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_code_d = chk_code;
                    fail_reg_d  = chk_reg;
                end else if (r_q == C_LAST_REG) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    pass_d      = 1'b1;
                    fail_code_d = C_CODE_NONE;
                    fail_reg_d  = 5'd0;
                end else begin
                    r_d = r_q + 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                r_d     = 5'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode from the upcoming state
    // ------------------------------------------------------------------------
    always_comb begin
        write_data_d = 32'd0;
        rd_reg1_d    = 5'd0;
        rd_reg2_d    = 5'd0;
        wr_reg_d     = 5'd0;
        reg_write_d  = 1'b0;
        busy_d       = 1'b0;

        case (state_d)
            S_WRZ: begin
                write_data_d = C_WRZ_DATA;
                reg_write_d  = 1'b1;
                busy_d       = 1'b1;
            end
            S_FILL: begin
                wr_reg_d     = r_d;
                write_data_d = pattern(r_d);
                reg_write_d  = 1'b1;
                busy_d       = 1'b1;
            end
            S_NOWE: begin
                wr_reg_d     = r_d;
                write_data_d = NOWE_DATA;
                busy_d       = 1'b1;
            end
            S_CHECK: begin
                rd_reg1_d = r_d;
                rd_reg2_d = C_LAST_REG - r_d;
                busy_d    = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            r_q          <= 5'd0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_code_q  <= C_CODE_NONE;
            fail_reg_q   <= 5'd0;
            write_data_q <= 32'd0;
            rd_reg1_q    <= 5'd0;
            rd_reg2_q    <= 5'd0;
            wr_reg_q     <= 5'd0;
            reg_write_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_code_q  <= fail_code_d;
            fail_reg_q   <= fail_reg_d;
            write_data_q <= write_data_d;
            rd_reg1_q    <= rd_reg1_d;
            rd_reg2_q    <= rd_reg2_d;
            wr_reg_q     <= wr_reg_d;
            reg_write_q  <= reg_write_d;
            busy_q       <= busy_d;
        end
    end

    assign WriteData     = write_data_q;
    assign ReadRegister1 = rd_reg1_q;
    assign ReadRegister2 = rd_reg2_q;
    assign WriteRegister = wr_reg_q;
    assign RegWrite      = reg_write_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Pass          = pass_q;
    assign FailCode      = fail_code_q;
    assign FailReg       = fail_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_bist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_bist
//  Purpose  : Self-checking bench for regfile_bist. A behavioural register
//             file with selectable faults sits on the DUT's regfile ports;
//             expected results per run are queued when Start is driven and
//             compared when Done rises.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_regfile_bist;

    localparam logic [31:0] C_NOWE = 32'hDEADBEEF;

    // Regfile fault modes
    localparam int C_M_GOOD   = 0;  // correct register file
    localparam int C_M_NOWE   = 1;  // ignores RegWrite
    localparam int C_M_REG0   = 2;  // reg 0 writable
    localparam int C_M_FIX17  = 3;  // both read ports stuck on reg 17
    localparam int C_M_A2B0   = 4;  // port-2 address bit 0 stuck low

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [31:0] ReadData1, ReadData2, WriteData;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister, FailReg;
    logic        RegWrite, Busy, Done, Pass;
    logic [2:0]  FailCode;

    int          mode;
    logic        rf_clr;
    logic [31:0] rf [32];
    logic [4:0]  a1, a2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        pass;
        logic [2:0]  code;
        logic [4:0]  freg;
        logic [31:0] lat;
    } exp_t;

    exp_t sb [$];

    always #5 Clk = ~Clk;

    regfile_bist dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Start         (Start),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteRegister (WriteRegister),
        .RegWrite      (RegWrite),
        .Busy          (Busy),
        .Done          (Done),
        .Pass          (Pass),
        .FailCode      (FailCode),
        .FailReg       (FailReg)
    );

    // Behavioural register file with fault injection
    always @(posedge Clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if ((RegWrite || mode == C_M_NOWE) &&
                     (WriteRegister != 5'd0 || mode == C_M_REG0)) begin
            rf[WriteRegister] <= WriteData;
        end
    end

    always_comb begin
        a1 = ReadRegister1;
        a2 = ReadRegister2;
        if (mode == C_M_FIX17) begin
            a1 = 5'd17;
            a2 = 5'd17;
        end else if (mode == C_M_A2B0) begin
            a2 = {ReadRegister2[4:1], 1'b0};
        end
        ReadData1 = rf[a1];
        ReadData2 = rf[a2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wdata"}, WriteData, 32'd0);
        check({tag, "_addr"}, {17'd0, ReadRegister1, ReadRegister2, WriteRegister}, 32'd0);
        check({tag, "_ctl"}, {20'd0, RegWrite, Busy, Done, Pass, FailCode, FailReg}, 32'd0);
    endtask

    task automatic clear_rf();
        rf_clr = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        rf_clr = 1'b0;
    endtask

    // One complete self-test run against regfile mode m. Optionally pokes
    // Start mid-run, which must be ignored.
    task automatic run_test(input int m, input logic e_pass, input logic [2:0] e_code,
                            input logic [4:0] e_reg, input int e_lat, input bit poke);
        int   cyc, n_busy, n_wr, n_nowe;
        exp_t e;
        mode = m;
        clear_rf();
        sb.push_back('{pass: e_pass, code: e_code, freg: e_reg, lat: e_lat});
        Start = 1'b1;
        @(posedge Clk);
        cyc = 0; n_busy = 0; n_wr = 0; n_nowe = 0;
        @(negedge Clk);
        Start = 1'b0;
        check("start_clears", {29'd0, Done, Pass, |FailCode}, 32'd0);
        while (!Done && cyc < 200) begin
            if (Busy) n_busy++;
            if (Busy && RegWrite) n_wr++;
            if (Busy && !RegWrite && WriteData == C_NOWE) n_nowe++;
            Start = (poke && cyc == 20);
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
        end
        Start = 1'b0;
        if (!Done) check("done_timeout", 32'(cyc), 32'(e_lat));
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("pass", {31'd0, Pass}, {31'd0, e.pass});
            check("failcode", {29'd0, FailCode}, {29'd0, e.code});
            check("failreg", {27'd0, FailReg}, {27'd0, e.freg});
            check("latency", 32'(cyc), e.lat);
            check("busy_cycles", 32'(n_busy), e.lat);
            check("we_writes", 32'(n_wr), 32'd32);
            check("nowe_cycles", 32'(n_nowe), 32'd31);
        end
        // Results must hold in DONE
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("done_hold", {20'd0, RegWrite, Busy, Done, Pass, FailCode, FailReg},
              {20'd0, 1'b0, 1'b0, 1'b1, e_pass, e_code, e_reg});
    endtask

    initial begin
        int cyc;
        mode    = C_M_GOOD;
        rf_clr  = 1'b1;
        Reset_n = 1'b0;
        Start   = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        rf_clr = 1'b0;
        check_idle_outputs("reset");

        // Start held while in reset is ignored
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start   = 1'b0;
        Reset_n = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check_idle_outputs("start_in_reset");

        run_test(C_M_GOOD,  1'b1, 3'd0, 5'd0,  95, 1'b1);
        run_test(C_M_NOWE,  1'b0, 3'd2, 5'd31, 64, 1'b0);
        run_test(C_M_REG0,  1'b0, 3'd1, 5'd0,  64, 1'b0);
        run_test(C_M_FIX17, 1'b0, 3'd1, 5'd0,  64, 1'b0);
        run_test(C_M_A2B0,  1'b0, 3'd4, 5'd31, 64, 1'b0);

        // Abort during NOWE at r=10, then rerun cleanly from IDLE
        mode = C_M_GOOD;
        clear_rf();
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        cyc = 0;
        while (!(Busy && !RegWrite && WriteRegister == 5'd10) && cyc < 200) begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
        end
        check("nowe_r10_reached", 32'(cyc), 32'd41);
        Reset_n = 1'b0;
        Start   = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check_idle_outputs("mid_reset");
        @(posedge Clk);
        @(negedge Clk);
        check_idle_outputs("mid_reset_hold");
        Start   = 1'b0;
        Reset_n = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        run_test(C_M_GOOD, 1'b1, 3'd0, 5'd0, 95, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
